// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, state encoding and helpers for the iterative divider
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Two's-complement negate when neg is set, modulo 2^DIV_W.
    function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational restoring shift-subtract step
module div_iter_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] rem_i,
    input  logic [DIV_W-1:0] quo_i,
    input  logic [DIV_W-1:0] dsr_i,
    output logic [DIV_W-1:0] rem_o,
    output logic [DIV_W-1:0] quo_o
);

    logic [DIV_W:0] part;
    logic [DIV_W:0] diff;

    // No borrow out of the 33-bit subtract means the partial remainder >= divisor.
    always_comb begin
        part = {rem_i, quo_i[DIV_W-1]};
        diff = part - {1'b0, dsr_i};
        if (!diff[DIV_W]) begin
            rem_o = diff[DIV_W-1:0];
            quo_o = {quo_i[DIV_W-2:0], 1'b1};
        end else begin
            rem_o = part[DIV_W-1:0];
            quo_o = {quo_i[DIV_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative 32-bit radix-2 divider with dual operand stream inputs
module div_iter
    import div_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    input  logic [DIV_W-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    output logic [2*DIV_W-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tvalid
);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dsr_cap_q, dsr_cap_d;
    logic                dvd_cap_q, dvd_cap_d;
    logic [DIV_W-1:0]    rem_q, rem_d;
    logic [DIV_W-1:0]    quo_q, quo_d;
    logic [DIV_W-1:0]    dsr_q, dsr_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [2*DIV_W-1:0]  dout_q, dout_d;
    logic                dout_vld_q, dout_vld_d;

    logic                dsr_rdy, dvd_rdy, dsr_hs, dvd_hs, pair;
    logic                dsr_sign, dvd_sign;
    logic [DIV_W-1:0]    dsr_raw, dvd_raw;
    logic [DIV_W-1:0]    step_rem, step_quo;

    div_iter_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign dsr_rdy = (state_q == IDLE) && !dsr_cap_q;
    assign dvd_rdy = (state_q == IDLE) && !dvd_cap_q;
    assign dsr_hs  = s_axis_divisor_tvalid && dsr_rdy;
    assign dvd_hs  = s_axis_dividend_tvalid && dvd_rdy;

    // While waiting for its partner, a captured operand is parked raw in dsr_q / quo_q.
    assign dsr_raw  = dsr_hs ? s_axis_divisor_tdata : dsr_q;
    assign dvd_raw  = dvd_hs ? s_axis_dividend_tdata : quo_q;
    assign pair     = (dsr_cap_q || dsr_hs) && (dvd_cap_q || dvd_hs);
    assign dsr_sign = SIGNED && dsr_raw[DIV_W-1];
    assign dvd_sign = SIGNED && dvd_raw[DIV_W-1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dsr_cap_d  = dsr_cap_q;
        dvd_cap_d  = dvd_cap_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dsr_d      = dsr_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dsr_hs) begin
                    dsr_cap_d = 1'b1;
                    dsr_d     = dsr_raw;
                end
                if (dvd_hs) begin
                    dvd_cap_d = 1'b1;
                    quo_d     = dvd_raw;
                end
                if (pair) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = cond_neg(dvd_raw, dvd_sign);
                    dsr_d   = cond_neg(dsr_raw, dsr_sign);
                    qneg_d  = dvd_sign ^ dsr_sign;
                    rneg_d  = dvd_sign;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                dout_d     = {cond_neg(quo_q, qneg_q), cond_neg(rem_q, rneg_q)};
                dout_vld_d = 1'b1;
                dsr_cap_d  = 1'b0;
                dvd_cap_d  = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dsr_cap_q  <= 1'b0;
            dvd_cap_q  <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            dsr_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dsr_cap_q  <= dsr_cap_d;
            dvd_cap_q  <= dvd_cap_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dsr_q      <= dsr_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign s_axis_divisor_tready  = dsr_rdy;
    assign s_axis_dividend_tready = dvd_rdy;
    assign m_axis_dout_tdata      = dout_q;
    assign m_axis_dout_tvalid     = dout_vld_q;

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 divider. It is the responder end of the divisor/dividend/dout stream interface that the execute stage drives for DIV/DIVU, and it replaces a vendor divider IP. One instance per signedness: the execute stage instantiates one with SIGNED=1 and one with SIGNED=0. It collects both operands through independent valid/ready channels, runs 32 shift-subtract iterations, and presents `{quotient, remainder}` on a non-blocking output channel.

## Interface
- `SIGNED`, default 1: 1 = two's-complement divide (DIV), 0 = unsigned divide (DIVU).
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state.
- `s_axis_divisor_tdata`, input, 32: divisor.
- `s_axis_divisor_tvalid`, input, 1: divisor offered.
- `s_axis_divisor_tready`, output, 1: divisor slot can accept.
- `s_axis_dividend_tdata`, input, 32: dividend.
- `s_axis_dividend_tvalid`, input, 1: dividend offered.
- `s_axis_dividend_tready`, output, 1: dividend slot can accept.
- `m_axis_dout_tdata`, output, 64: `[63:32]` quotient, `[31:0]` remainder.
- `m_axis_dout_tvalid`, output, 1: one-cycle result strobe; no tready.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - Each channel has a captured flag.
  - `tready` of a channel = (state==IDLE) & !captured.
  - A handshake is tvalid & tready at a rising edge. It latches the data and sets that channel's flag.
- **Operand pairing:**
  - The channels are accepted in either order, or in the same cycle.
  - The edge that completes the pair loads the datapath and moves to CALC.
- **Datapath load:**
  - SIGNED=1: magnitudes |dividend| and |divisor| are loaded.
  - Sign bits are recorded: qneg = sign(dividend) ^ sign(divisor), rneg = sign(dividend).
  - SIGNED=0: raw values are loaded and qneg = rneg = 0.
- **CALC:**
  - A 5-bit counter runs 0..31, one restoring step per cycle.
  - Each step: partial remainder (33 bits) = {rem, q[31]}; q shifts left.
  - If rem ≥ divisor: subtract and shift 1 into q. Otherwise shift 0.
  - Count 31 moves to DONE.
- **DONE:**
  - `tdata` is registered: quotient = qneg ? −q : q, remainder = rneg ? −rem : rem, modulo 2^32.
  - `tvalid` = 1 for this one cycle.
  - Both captured flags clear, and the next edge returns to IDLE.
- **Divide by zero:** no special case. The algorithm result is produced:
  - Unsigned: q = 0xFFFFFFFF, r = dividend.
  - Signed, dividend ≥ 0: q = 0xFFFFFFFF, r = dividend.
  - Signed, dividend < 0: q = 0x00000001, r = dividend.
- **Overflow:** 0x80000000 / 0xFFFFFFFF signed gives q = 0x80000000, r = 0.
- **Output hold:** `m_axis_dout_tdata` stays stable from DONE until the next DONE.

## Timing
- **Reset values:**
  - state = IDLE, flags = 0, `m_axis_dout_tvalid` = 0, `m_axis_dout_tdata` = 0.
  - Both `tready` = 1 while reset is held and immediately after.
- **Latency:** if the pair completes at edge T, `tvalid` is high in the cycle after edge T+33, i.e. 33 cycles of occupancy.
- **Throughput:** one division per 34 cycles minimum. The next pair may handshake in the first IDLE cycle after DONE.
- **Backpressure:** both `tready` are low throughout CALC and DONE. A tvalid held by the sender is simply waited on.
- **Partial capture:** a channel already captured keeps `tready` low. It does not accept a second value until DONE.
- **Reset mid-CALC or mid-DONE:**
  - Returns to IDLE asynchronously and drops `tvalid` immediately.
  - The in-flight result is lost.
  - `tdata` is cleared to 0.
- **Same cycle as a handshake:** none of the outputs is combinational on the tdata inputs.

## Structure
- **Package `div_pkg`:** state encoding constants (IDLE=2'd0, CALC=2'd1, DONE=2'd2), `DIV_W`=32, iteration count 32.
- **Sub-module `div_iter_step`:** combinational, one restoring step. Inputs are partial remainder, quotient and divisor; outputs are the next remainder and quotient. It is instantiated once and used every CALC cycle.
- **Top level:** channel flags, FSM, counter, abs/negate logic.

## Test plan
- **Unsigned, same cycle:** SIGNED=0, dividend 100 and divisor 7 handshake at edge T. `tvalid` for one cycle after T+33 with tdata 0x0000000E_00000002. Both `tready` are low for the intervening cycles.
- **Signed, split handshake:**
  - SIGNED=1, dividend 0xFFFFFFF9 (−7) at T, divisor 2 at T+5.
  - Result 0xFFFFFFFD_FFFFFFFF after T+38.
  - Dividend `tready` is low from T+1.
- **Signed corners:**
  - 0x80000000 / 0xFFFFFFFF gives 0x80000000_00000000.
  - 0xFFFFFFF9 / 0 gives 0x00000001_FFFFFFF9.
- **Unsigned divide by zero:** 0x12345678 / 0 gives 0xFFFFFFFF_12345678.
- **Reset during CALC:** assert `reset` at iteration 10.
  - `tvalid` stays 0 and tdata becomes 0.
  - A following 9/3 completes with 0x00000003_00000000 at full latency.
- **Back-to-back:** hold both tvalid high across two divisions. The second pair is accepted in the IDLE cycle right after DONE. Two strobes occur 34 cycles apart and tdata is held between them.
